// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter states and word type.
// Also holds the saturating increment used by the dcache streak counter.
package mem_arbiter_pkg;

  localparam int WORD_W   = 32;
  localparam int STREAK_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } arb_state_t;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                   input logic [STREAK_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/RAM side bus of the memory arbiter. master = arbiter, slave = caches and RAM.
// Handshake: a cache raises REN/WEN and holds it (address/data stable) until its wait goes
// low; that low cycle is the one completion cycle, granted only when ramstate == ACCESS.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = WORD_W
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  ramstate_t         ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache accesses onto one RAM port. dcache wins ties, but after
// MAX_D_STREAK back-to-back dcache grants with iREN pending the icache is forced through.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int MAX_D_STREAK = 4,
  parameter int ADDR_W       = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_arbiter_if.master       bus,
  output arb_state_t          dbg_state,
  output logic [STREAK_W-1:0] dbg_streak
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [ADDR_W-1:0]   ZERO_W     = '0;

  arb_state_t          state, next_state;
  logic [STREAK_W-1:0] streak, next_streak;
  logic                d_req;
  logic                i_starved;
  logic                ram_done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= next_state;
      streak <= next_streak;
    end
  end

  assign d_req      = bus.dREN | bus.dWEN;
  assign i_starved  = bus.iREN && (streak == STREAK_MAX);
  assign ram_done   = (bus.ramstate == ACCESS);
  assign dbg_state  = state;
  assign dbg_streak = streak;

  // Outputs are decoded from the registered state; ERROR/BUSY/FREE simply hold the request.
  always_comb begin
    next_state   = state;
    next_streak  = streak;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = ZERO_W;
    bus.dload    = ZERO_W;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ZERO_W;
    bus.ramstore = ZERO_W;
    unique case (state)
      IDLE: begin
        if (d_req && !i_starved) next_state = SERVE_D;
        else if (bus.iREN)       next_state = SERVE_I;
      end
      SERVE_D: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          bus.ramaddr = bus.daddr;
          if (bus.dWEN) begin
            bus.ramWEN   = 1'b1;
            bus.ramstore = bus.dstore;
          end else begin
            bus.ramREN = 1'b1;
          end
          if (ram_done) begin
            bus.dwait   = 1'b0;
            bus.dload   = bus.ramload;
            next_state  = IDLE;
            next_streak = bus.iREN ? sat_inc(streak, STREAK_MAX) : '0;
          end
        end
      end
      SERVE_I: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (ram_done) begin
            bus.iwait   = 1'b0;
            bus.iload   = bus.ramload;
            next_state  = IDLE;
            next_streak = '0;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Downstream neighbour of the instruction cache. Arbitrates single-word icache fills and dcache read/write requests onto the single-ported RAM. Registered grant FSM; dcache has priority, with a bounded-streak fairness counter so instruction fetch cannot starve. Drives the iwait/iload and dwait/dload returns that the caches consume.

Parameters:
MAX_D_STREAK, 4, number of consecutive dcache grants allowed while iREN is pending before icache is forced a grant (1..15)
ADDR_W, 32, address/data word width (word_t)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  icache read request (held until iwait low)
iaddr  in  32  icache word address
iwait  out  1  low for exactly the cycle iload is valid
iload  out  32  instruction word to icache
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  low for exactly the cycle the dcache access completes
dload  out  32  read data to dcache
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (async, nRST=0): state=IDLE, streak=0; iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0. Reset mid-transaction abandons it; no completion is signalled.
- States: IDLE, SERVE_D, SERVE_I.
- IDLE: ram enables 0, both waits 1. At the clock edge:
  - If dREN|dWEN and not (iREN and streak==MAX_D_STREAK) -> SERVE_D.
  - Else if iREN -> SERVE_I.
  - Else stay IDLE.
- SERVE_D: ramaddr=daddr. dWEN=1 -> ramWEN=1, ramstore=dstore, ramREN=0. Else ramREN=1. dWEN wins if dREN and dWEN are both high. iwait=1.
  - ramstate==ACCESS: dwait=0 this cycle (combinational); dload=ramload. Next state IDLE. streak <= iREN ? sat(streak+1) : 0.
  - FREE/BUSY: hold state and outputs.
  - ERROR: dwait stays 1, request remains asserted (retry), hold state.
  - dREN=dWEN=0 (request dropped): ram enables 0, next IDLE, streak unchanged.
- SERVE_I: ramREN=1, ramaddr=iaddr, ramWEN=0, dwait=1.
  - ACCESS: iwait=0, iload=ramload, next IDLE, streak <= 0.
  - ERROR and BUSY handled as in SERVE_D. iREN dropped -> IDLE.
- Latency: request sampled in IDLE at edge N; RAM driven from N+1; completion in the first ACCESS cycle; one IDLE arbitration cycle between back-to-back transactions. Minimum request-to-wait-low = 2 cycles.
- Exactly one of iwait/dwait may be low in any cycle. ramREN and ramWEN are never both 1. Outside ACCESS cycles, iload/dload are 0.
- streak saturates at MAX_D_STREAK and clears when iREN is low at a dcache completion, or on any icache completion.

Decomposition:
- cpu_types_pkg: ramstate_t (if not already present), arb_state_t enum {IDLE, SERVE_D, SERVE_I}, word_t.
- No sub-module; the streak counter is inline. Module wrapped for cache_control_if as the memory-control modport.

Test Plan:
- Lone ifetch: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with 0x3C010001 -> iwait low exactly 1 cycle, iload=0x3C010001, ramREN high 3 cycles.
- Simultaneous: iREN and dREN at the same edge, daddr=0x100 -> dcache served first (dwait low, dload=ramload); icache served in the next transaction; iwait never low at the same time as dwait.
- Starvation (MAX_D_STREAK=4): dREN held continuously with iREN pending -> exactly 4 dcache completions, then one icache completion, then dcache resumes; streak returns to 0.
- Write: dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low on ACCESS.
- ERROR retry: ramstate=ERROR for 3 cycles, then ACCESS -> waits stay 1 during ERROR, enables held, single completion afterwards.
- Reset mid-SERVE_I, and request dropped mid-SERVE_D -> all outputs at reset/idle values the same cycle (reset) or next cycle (drop); no spurious wait-low.
